// File: rtl/servo_pkg.sv
// Shared types and constants for the servo sweep controller: FSM states,
// Avalon register map and default timing for a 50 MHz clock.
package servo_pkg;

  typedef enum logic [1:0] {
    SWEEP_UP   = 2'd0,
    INT_MAX    = 2'd1,
    SWEEP_DOWN = 2'd2,
    INT_MIN    = 2'd3
  } sweep_state_t;

  localparam logic [1:0] ADDR_MIN  = 2'd0;
  localparam logic [1:0] ADDR_MAX  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_ACK  = 2'd3;

  localparam int DEF_PERIOD_CYC = 1_000_000;
  localparam int DEF_STEP_CYC   = 500;
  localparam int DEF_MIN_RST    = 50_000;
  localparam int DEF_MAX_RST    = 100_000;
  localparam int DEF_W          = 20;

endpackage

// File: rtl/servo_pwm_gen.sv
// Fixed-period PWM generator: free-running period counter, width compare
// and a one-cycle pulse on the last cycle of each period.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int W          = DEF_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] cur_width,
  output logic         pwm_out,
  output logic         period_end
);

  localparam logic [W-1:0] LAST_CNT = W'(PERIOD_CYC - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt <= '0;
    else if (!enable)         cnt <= '0;
    else if (cnt == LAST_CNT) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // Gating with enable also drops the pulse the moment reset clears enable.
  assign pwm_out    = enable && (cnt < cur_width);
  assign period_end = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Avalon-MM servo sweep controller: limit/control registers, sweep FSM with
// interrupt handshake at each end, and the PWM generator instance.
module servo_sweep_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int STEP_CYC   = DEF_STEP_CYC,
  parameter int MIN_RST    = DEF_MIN_RST,
  parameter int MAX_RST    = DEF_MAX_RST,
  parameter int W          = DEF_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        pwm_out,
  output logic        irq
);

  localparam logic [W:0] STEP_X = (W+1)'(STEP_CYC);

  sweep_state_t state, state_nxt;
  logic [W-1:0] min_w, max_w, cur_width, cur_nxt;
  logic         enable, ack_pending, period_end;
  logic         enter_int, ack_consume, in_int;
  logic [W:0]   min_x, max_x, cur_x, up_sum, up_nxt, dn_diff, dn_nxt;
  logic         unused_wdata;

  wire wr_min  = write && (address == ADDR_MIN);
  wire wr_max  = write && (address == ADDR_MAX);
  wire wr_ctrl = write && (address == ADDR_CTRL);
  wire wr_ack  = write && (address == ADDR_ACK);

  assign unused_wdata = ^writedata[31:W];

  servo_pwm_gen #(.PERIOD_CYC(PERIOD_CYC), .W(W)) u_pwm (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .cur_width (cur_width),
    .pwm_out   (pwm_out),
    .period_end(period_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SWEEP_UP;
    else          state <= state_nxt;
  end

  // One extra bit keeps cur+STEP from wrapping; the subtract saturates at 0.
  assign min_x   = {1'b0, min_w};
  assign max_x   = {1'b0, max_w};
  assign cur_x   = {1'b0, cur_width};
  assign up_sum  = cur_x + STEP_X;
  assign up_nxt  = (up_sum > max_x) ? max_x : up_sum;
  assign dn_diff = (cur_x > STEP_X) ? (cur_x - STEP_X) : '0;
  assign dn_nxt  = (dn_diff < min_x) ? min_x : dn_diff;

  // NOTE: every output of this block gets a default first so no path
  // through the case can infer a latch.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur_width;
    enter_int   = 1'b0;
    ack_consume = 1'b0;
    if (period_end) begin
      unique case (state)
        SWEEP_UP: begin
          if (up_nxt >= max_x) begin
            cur_nxt   = max_w;
            state_nxt = INT_MAX;
            enter_int = 1'b1;
          end else if (up_nxt < min_x) begin
            cur_nxt = min_w;
          end else begin
            cur_nxt = up_nxt[W-1:0];
          end
        end
        SWEEP_DOWN: begin
          if (dn_nxt <= min_x) begin
            cur_nxt   = min_w;
            state_nxt = INT_MIN;
            enter_int = 1'b1;
          end else if (dn_nxt > max_x) begin
            cur_nxt = max_w;
          end else begin
            cur_nxt = dn_nxt[W-1:0];
          end
        end
        INT_MAX: if (ack_pending) begin
          state_nxt   = SWEEP_DOWN;
          ack_consume = 1'b1;
        end
        INT_MIN: if (ack_pending) begin
          state_nxt   = SWEEP_UP;
          ack_consume = 1'b1;
        end
        default: state_nxt = SWEEP_UP;
      endcase
    end
  end

  always_comb begin
    in_int = (state == INT_MAX) || (state == INT_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_width   <= W'(MIN_RST);
      min_w       <= W'(MIN_RST);
      max_w       <= W'(MAX_RST);
      enable      <= 1'b0;
      ack_pending <= 1'b0;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      cur_width <= cur_nxt;
      if (wr_min)  min_w  <= writedata[W-1:0];
      if (wr_max)  max_w  <= writedata[W-1:0];
      if (wr_ctrl) enable <= writedata[0];

      // Acks outside an INT state are dropped so they cannot cause an early reversal.
      if (enter_int)             irq <= 1'b1;
      else if (wr_ack && in_int) irq <= 1'b0;

      if (ack_consume)           ack_pending <= 1'b0;
      else if (wr_ack && in_int) ack_pending <= 1'b1;

      if (read) begin
        unique case (address)
          ADDR_MIN:  readdata <= 32'(min_w);
          ADDR_MAX:  readdata <= 32'(max_w);
          ADDR_CTRL: readdata <= 32'({state, cur_width});
          default:   readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Directed bench for servo_sweep_ctrl with a 100-cycle period, step 5,
// limits 20..40. Inputs change and outputs are sampled on the falling edge.
module tb_servo_sweep_ctrl;
  import servo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        pwm_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  servo_sweep_ctrl #(
    .PERIOD_CYC(100), .STEP_CYC(5), .MIN_RST(20), .MAX_RST(40), .W(20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .read     (read),
    .readdata (readdata),
    .pwm_out  (pwm_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status(input logic [1:0] st, input int w);
    return (32'(st) << 20) | 32'(w);
  endfunction

  // Each bus access consumes exactly one clock; called and returns on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic run(input int n, output int high, output int irq_hi);
    high = 0; irq_hi = 0;
    repeat (n) begin
      if (pwm_out === 1'b1) high++;
      if (irq === 1'b1) irq_hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int h, q;
    reset_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", readdata); end
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(SWEEP_UP, 20)) begin errors++; $display("FAIL rst_status: got %h want %h", readdata, status(SWEEP_UP, 20)); end
    bus_read(ADDR_MIN);
    checks++; if (readdata !== 32'd20) begin errors++; $display("FAIL rst_min: got %0d want 20", readdata); end
    bus_read(ADDR_MAX);
    checks++; if (readdata !== 32'd40) begin errors++; $display("FAIL rst_max: got %0d want 40", readdata); end
    run(150, h, q);
    checks++; if (h !== 0 || q !== 0) begin errors++; $display("FAIL rst_idle: pwm high %0d irq high %0d want 0 0", h, q); end
  endtask

  task automatic test_sweep_up;
    int h, q;
    int exp_w[4] = '{20, 25, 30, 35};
    bus_write(ADDR_CTRL, 32'd1);
    for (int i = 0; i < 4; i++) begin
      run(100, h, q);
      checks++; if (h !== exp_w[i] || q !== 0) begin errors++; $display("FAIL up_width[%0d]: high %0d irq %0d want %0d 0", i, h, q, exp_w[i]); end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL up_irq_rise: got %b want 1", irq); end
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(INT_MAX, 40)) begin errors++; $display("FAIL up_status: got %h want %h", readdata, status(INT_MAX, 40)); end
    run(99, h, q);
    checks++; if (h !== 39) begin errors++; $display("FAIL up_int_width: high %0d want 39", h); end
  endtask

  task automatic test_hold_and_down;
    int h, q;
    int exp_w[4] = '{40, 35, 30, 25};
    for (int i = 0; i < 3; i++) begin
      run(100, h, q);
      checks++; if (h !== 40 || q !== 100) begin errors++; $display("FAIL hold[%0d]: high %0d irq %0d want 40 100", i, h, q); end
    end
    bus_write(ADDR_ACK, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq_fall: got %b want 0", irq); end
    run(99, h, q);
    checks++; if (h !== 39 || q !== 0) begin errors++; $display("FAIL ack_rest: high %0d irq %0d want 39 0", h, q); end
    for (int i = 0; i < 4; i++) begin
      run(100, h, q);
      checks++; if (h !== exp_w[i] || q !== 0) begin errors++; $display("FAIL down_width[%0d]: high %0d irq %0d want %0d 0", i, h, q, exp_w[i]); end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL down_irq_rise: got %b want 1", irq); end
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(INT_MIN, 20)) begin errors++; $display("FAIL down_status: got %h want %h", readdata, status(INT_MIN, 20)); end
    run(99, h, q);
    checks++; if (h !== 19) begin errors++; $display("FAIL down_int_width: high %0d want 19", h); end
  endtask

  task automatic test_max_clamp;
    int h, q;
    bus_write(ADDR_ACK, 32'd0);
    run(99, h, q);
    checks++; if (h !== 19) begin errors++; $display("FAIL rev_up_int: high %0d want 19", h); end
    run(100, h, q);
    checks++; if (h !== 20) begin errors++; $display("FAIL rev_up_first: high %0d want 20", h); end
    run(100, h, q);
    checks++; if (h !== 25) begin errors++; $display("FAIL rev_up_second: high %0d want 25", h); end
    bus_write(ADDR_MAX, 32'd33);
    run(99, h, q);
    checks++; if (h !== 29) begin errors++; $display("FAIL clamp_pre: high %0d want 29", h); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clamp_irq: got %b want 1", irq); end
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(INT_MAX, 33)) begin errors++; $display("FAIL clamp_status: got %h want %h", readdata, status(INT_MAX, 33)); end
    run(99, h, q);
    checks++; if (h !== 32) begin errors++; $display("FAIL clamp_width: high %0d want 32", h); end
  endtask

  task automatic test_ack_ignored;
    int h, q;
    int exp_dn[3] = '{33, 28, 23};
    int exp_up[3] = '{25, 30, 35};
    bus_write(ADDR_MAX, 32'd40);
    bus_write(ADDR_ACK, 32'd0);
    run(98, h, q);
    checks++; if (h !== 31 || q !== 0) begin errors++; $display("FAIL ign_leave: high %0d irq %0d want 31 0", h, q); end
    for (int i = 0; i < 3; i++) begin
      run(100, h, q);
      checks++; if (h !== exp_dn[i]) begin errors++; $display("FAIL ign_down[%0d]: high %0d want %0d", i, h, exp_dn[i]); end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ign_min_irq: got %b want 1", irq); end
    bus_write(ADDR_ACK, 32'd0);
    run(99, h, q);
    checks++; if (h !== 19) begin errors++; $display("FAIL ign_min_int: high %0d want 19", h); end
    bus_write(ADDR_ACK, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ign_sweep_irq: got %b want 0", irq); end
    run(99, h, q);
    checks++; if (h !== 19 || q !== 0) begin errors++; $display("FAIL ign_sweep_rest: high %0d irq %0d want 19 0", h, q); end
    for (int i = 0; i < 3; i++) begin
      run(100, h, q);
      checks++; if (h !== exp_up[i] || q !== 0) begin errors++; $display("FAIL ign_up[%0d]: high %0d irq %0d want %0d 0", i, h, q, exp_up[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      run(100, h, q);
      checks++; if (h !== 40 || q !== 100) begin errors++; $display("FAIL ign_hold[%0d]: high %0d irq %0d want 40 100", i, h, q); end
    end
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(INT_MAX, 40)) begin errors++; $display("FAIL ign_status: got %h want %h", readdata, status(INT_MAX, 40)); end
    run(99, h, q);
    checks++; if (h !== 39) begin errors++; $display("FAIL ign_realign: high %0d want 39", h); end
  endtask

  task automatic test_disable;
    int h, q;
    run(10, h, q);
    checks++; if (h !== 10 || pwm_out !== 1'b1) begin errors++; $display("FAIL dis_pre: high %0d pwm %b want 10 1", h, pwm_out); end
    bus_write(ADDR_CTRL, 32'd0);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL dis_fall: got %b want 0", pwm_out); end
    run(300, h, q);
    checks++; if (h !== 0 || q !== 300) begin errors++; $display("FAIL dis_hold: high %0d irq %0d want 0 300", h, q); end
    bus_write(ADDR_CTRL, 32'd1);
    run(100, h, q);
    checks++; if (h !== 40 || q !== 100) begin errors++; $display("FAIL dis_resume: high %0d irq %0d want 40 100", h, q); end
  endtask

  task automatic test_reset_mid;
    int h, q;
    bus_write(ADDR_MIN, 32'd35);
    bus_write(ADDR_ACK, 32'd0);
    run(98, h, q);
    checks++; if (h !== 38) begin errors++; $display("FAIL mid_leave: high %0d want 38", h); end
    run(100, h, q);
    checks++; if (h !== 40 || q !== 0) begin errors++; $display("FAIL mid_down: high %0d irq %0d want 40 0", h, q); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq: got %b want 1", irq); end
    run(10, h, q);
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(INT_MIN, 35) || pwm_out !== 1'b1) begin errors++; $display("FAIL mid_status: got %h pwm %b want %h 1", readdata, pwm_out, status(INT_MIN, 35)); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 1'b0 || irq !== 1'b0 || readdata !== 32'd0) begin errors++; $display("FAIL mid_async: pwm %b irq %b rdata %h want 0 0 0", pwm_out, irq, readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_CTRL);
    checks++; if (readdata !== status(SWEEP_UP, 20)) begin errors++; $display("FAIL mid_post_status: got %h want %h", readdata, status(SWEEP_UP, 20)); end
    bus_read(ADDR_MIN);
    checks++; if (readdata !== 32'd20) begin errors++; $display("FAIL mid_post_min: got %0d want 20", readdata); end
    run(100, h, q);
    checks++; if (h !== 0 || q !== 0) begin errors++; $display("FAIL mid_post_idle: high %0d irq %0d want 0 0", h, q); end
  endtask

  initial begin
    test_reset();
    test_sweep_up();
    test_hold_and_down();
    test_max_clamp();
    test_ack_ignored();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
